vga_pll_rst_seq: RTL and testbench
==================================

VGA_PLL_RST_SEQ -- requirements
Module: vga_pll_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: number of cycles to wait for lock before a retry.
REQ-004 SHALL have parameter MAX_RETRIES, default 4: number of consecutive lock timeouts before entering FAIL.
REQ-005 refclk  input  1  single clock, 50 MHz PLL reference; all logic in this domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 pll_locked  input  1  asynchronous lock indication from the 25 MHz VGA PLL.
REQ-008 retry  input  1  single-cycle pulse; leaves FAIL.
REQ-009 pll_rst  output  1  reset to the VGA PLL.
REQ-010 vga_rst  output  1  reset for downstream VGA timing logic; high while the pixel clock is not trusted.
REQ-011 ready  output  1  high exactly when vga_rst is low.
REQ-012 fail  output  1  high in FAIL state.
REQ-013 relock_count  output  8  count of lock losses seen in RUN; saturates at 255.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 The state machine SHALL have exactly these states: PRST, WAIT, STABLE, RUN, FAIL.
REQ-017 PRST: pll_rst=1; hold for exactly PLL_RST_CYCLES cycles; then go to WAIT with the cycle counter cleared.
REQ-018 WAIT, lock_s=1: go to STABLE with the counter cleared.
REQ-019 WAIT, counter reaches LOCK_TIMEOUT_CYCLES-1 without lock: increment retries; if retries now equals MAX_RETRIES go to FAIL, else go to PRST.
REQ-020 STABLE, lock_s drops: go to WAIT with the counter cleared; retries unchanged.
REQ-021 STABLE: after LOCK_STABLE_CYCLES consecutive cycles with lock_s=1, go to RUN and clear retries.
REQ-022 RUN: vga_rst=0, ready=1; pll_rst=0.
REQ-023 RUN, lock_s=0: go to PRST; vga_rst=1 and ready=0 on the same edge; relock_count increments, saturating at 255.
REQ-024 FAIL: pll_rst=0, vga_rst=1, ready=0, fail=1; remain until retry=1, then go to PRST with retries cleared.
REQ-025 vga_rst SHALL be 1 in every state except RUN.
REQ-026 The cycle counter SHALL be wide enough for the largest parameter and SHALL never wrap within a state.
REQ-027 retry SHALL be ignored in every state other than FAIL.
REQ-028 lock_s dropping on the same edge a timeout or stable count completes: the lock_s condition takes priority.

Reset
REQ-029 Asserting rst SHALL, on the next edge, enter PRST from any state with: counter=0, retries=0, relock_count=0, pll_rst=1, vga_rst=1, ready=0, fail=0.
REQ-030 rst asserted mid-operation (including during RUN or FAIL) SHALL restart the full sequence; relock_count is cleared.

Verification
(PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-031 Nominal: rst released at edge 0 -> pll_rst high edges 0-3, low from edge 4; pll_locked raised at edge 10 -> ready and !vga_rst from edge 20.
REQ-032 Glitch during STABLE: pll_locked low for 1 cycle 5 cycles into STABLE -> return to WAIT; ready rises 8 cycles after lock_s returns high; retries unchanged.
REQ-033 Lock loss in RUN: pll_locked drops -> 2 cycles later vga_rst=1 and ready=0, relock_count 0->1; pll_rst pulses for 4 cycles; relock completes normally.
REQ-034 No lock ever: two 32-cycle timeouts, each followed by a PLL reset pulse -> fail=1, pll_rst=0, vga_rst=1; a retry pulse -> PRST and pll_rst=1 on the next edge.
REQ-035 Saturation and reset: force 256 lock losses -> relock_count holds at 255; then rst -> all outputs return to their reset values (REQ-029) on the next edge.

Source files
------------

// File: rtl/vga_pll_rst_seq.sv
// vga_pll_rst_seq: drives the VGA PLL reset, qualifies its lock, and holds VGA logic in reset until the pixel clock is trusted.
module vga_pll_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry,
  output logic       pll_rst,
  output logic       vga_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_count
);
  localparam int MAXA = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAXC = MAXA > LOCK_TIMEOUT_CYCLES ? MAXA : LOCK_TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {PRST, WAIT, STABLE, RUN, FAIL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retries_q, retries_d;
  logic [7:0]    relock_q, relock_d;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic          pll_rst_q, vga_rst_q, ready_q, fail_q;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    retries_d = retries_q;
    relock_d  = relock_q;
    case (state_q)
      PRST: if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (lock_s) begin
        state_d = STABLE;
        cnt_d   = '0;
      end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
        retries_d = retries_q + RW'(1);
        state_d   = (retries_d == RW'(MAX_RETRIES)) ? FAIL : PRST;
        cnt_d     = '0;
      end
      // a lock drop outranks a stable count completing on the same edge
      STABLE: if (!lock_s) begin
        state_d = WAIT;
        cnt_d   = '0;
      end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
        state_d   = RUN;
        retries_d = '0;
        cnt_d     = '0;
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d  = PRST;
          relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
        end
      end
      FAIL: begin
        cnt_d = '0;
        if (retry) begin
          state_d   = PRST;
          retries_d = '0;
        end
      end
      default: begin
        state_d = PRST;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs are registered from the next state so they change on the same edge as the state
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PRST;
      cnt_q     <= '0;
      retries_q <= '0;
      relock_q  <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      vga_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      relock_q  <= relock_d;
      sync_q    <= {sync_q[0], pll_locked};
      pll_rst_q <= state_d == PRST;
      vga_rst_q <= state_d != RUN;
      ready_q   <= state_d == RUN;
      fail_q    <= state_d == FAIL;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign vga_rst      = vga_rst_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign relock_count = relock_q;
endmodule

// File: tb/tb_vga_pll_rst_seq.sv
// tb_vga_pll_rst_seq: directed and randomized checks of vga_pll_rst_seq against a cycle-level behavioural model.
module tb_vga_pll_rst_seq;
  localparam int PRC = 4, STC = 8, TOC = 32, MR = 2;
  localparam int PH_PRST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;

  logic refclk = 1'b0, rst, pll_locked, retry;
  logic pll_rst, vga_rst, ready, fail;
  logic [7:0] relock_count;

  vga_pll_rst_seq #(.PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(STC),
                    .LOCK_TIMEOUT_CYCLES(TOC), .MAX_RETRIES(MR)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry(retry),
    .pll_rst(pll_rst), .vga_rst(vga_rst), .ready(ready), .fail(fail),
    .relock_count(relock_count));

  always #5 refclk = ~refclk;

  int n_checks = 0, n_fail = 0, cyc = 0, e0 = 0;
  int m_phase = PH_PRST, m_t = 0, m_tries = 0, m_relock = 0;
  bit m_s0 = 0, m_s1 = 0, model_on = 0;

  always @(posedge refclk) cyc <= cyc + 1;

  // reference: lock is seen two edges after it is sampled; time in each phase counted in whole cycles
  always @(posedge refclk) begin
    bit ls;
    ls = m_s1;
    m_s1 = m_s0;
    m_s0 = pll_locked;
    if (rst) begin
      m_phase = PH_PRST; m_t = 0; m_tries = 0; m_relock = 0; m_s0 = 0; m_s1 = 0; model_on = 1;
    end else if (model_on) begin
      if (m_phase == PH_PRST) begin
        m_t++;
        if (m_t == PRC) begin m_phase = PH_WAIT; m_t = 0; end
      end else if (m_phase == PH_WAIT) begin
        m_t++;
        if (ls) begin m_phase = PH_STABLE; m_t = 0; end
        else if (m_t == TOC) begin
          m_tries++;
          m_phase = (m_tries == MR) ? PH_FAIL : PH_PRST;
          m_t = 0;
        end
      end else if (m_phase == PH_STABLE) begin
        m_t++;
        if (!ls) begin m_phase = PH_WAIT; m_t = 0; end
        else if (m_t == STC) begin m_phase = PH_RUN; m_t = 0; m_tries = 0; end
      end else if (m_phase == PH_RUN) begin
        if (!ls) begin
          m_phase = PH_PRST; m_t = 0;
          m_relock = (m_relock == 255) ? 255 : m_relock + 1;
        end
      end else if (retry) begin
        m_phase = PH_PRST; m_t = 0; m_tries = 0;
      end
    end
  end

  always @(negedge refclk) begin
    if (model_on) begin
      logic [11:0] act, exp_v;
      act   = {pll_rst, vga_rst, ready, fail, relock_count};
      exp_v = {m_phase == PH_PRST, m_phase != PH_RUN, m_phase == PH_RUN, m_phase == PH_FAIL, 8'(m_relock)};
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL model_cmp cyc=%0d {pll_rst,vga_rst,ready,fail,relock}: got %b expected %b", cyc, act, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < e0 + k) @(negedge refclk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge refclk);
    e0 = cyc;
    rst = 1'b0;
  endtask

  initial begin
    int len, w;
    bit lvl;
    rst = 1'b1; pll_locked = 1'b0; retry = 1'b0;
    do_reset;
    chk("reset_pll_rst", pll_rst, 1); chk("reset_ready", ready, 0);
    goto(3);  chk("prst_edge3", pll_rst, 1);
    goto(4);  chk("prst_edge4", pll_rst, 0); chk("wait_vga_rst", vga_rst, 1);
    goto(9);  pll_locked = 1'b1;
    goto(19); chk("ready_edge19", ready, 0);
    goto(20); chk("ready_edge20", ready, 1); chk("vga_rst_edge20", vga_rst, 0);
    goto(22); retry = 1'b1;
    goto(23); retry = 1'b0;
    goto(25); pll_locked = 1'b0;
    goto(27); chk("run_before_loss", ready, 1);
    goto(28); chk("loss_ready", ready, 0); chk("loss_vga_rst", vga_rst, 1);
              chk("loss_relock", relock_count, 1); chk("loss_pll_rst", pll_rst, 1);
    goto(29); pll_locked = 1'b1;
    goto(31); chk("relock_prst_last", pll_rst, 1);
    goto(32); chk("relock_prst_end", pll_rst, 0);
    goto(36); pll_locked = 1'b0;
    goto(37); pll_locked = 1'b1;
    goto(40); chk("glitch_no_run", ready, 0);
    goto(47); chk("glitch_ready47", ready, 0);
    goto(48); chk("glitch_ready48", ready, 1);

    pll_locked = 1'b0;
    do_reset;
    goto(10); retry = 1'b1;
    goto(11); retry = 1'b0;
    goto(35); chk("timeout1_before", pll_rst, 0);
    goto(36); chk("timeout1_prst", pll_rst, 1);
    goto(71); chk("fail_before", fail, 0);
    goto(72); chk("fail_set", fail, 1); chk("fail_pll_rst", pll_rst, 0); chk("fail_vga_rst", vga_rst, 1);
    goto(80); retry = 1'b1;
    goto(81); retry = 1'b0; chk("retry_pll_rst", pll_rst, 1); chk("retry_fail", fail, 0);
    goto(85); chk("retry_prst_end", pll_rst, 0);

    pll_locked = 1'b1;
    do_reset;
    for (int i = 0; i < 260; i++) begin
      w = 0;
      while (m_phase != PH_RUN && w < 200) begin @(negedge refclk); w++; end
      if (w >= 200) chk("wait_run_timeout", w, 0);
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      repeat (3) @(negedge refclk);
    end
    w = 0;
    while (m_phase != PH_RUN && w < 200) begin @(negedge refclk); w++; end
    chk("relock_saturated", relock_count, 255);
    do_reset;
    chk("rst_pll_rst", pll_rst, 1); chk("rst_vga_rst", vga_rst, 1); chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0); chk("rst_relock", relock_count, 0);

    lvl = 1'b0;
    for (int s = 0; s < 120; s++) begin
      len = $urandom_range(1, lvl ? 40 : 150);
      pll_locked = lvl;
      repeat (len) begin
        @(negedge refclk);
        retry = ($urandom_range(0, 15) == 0);
        rst   = ($urandom_range(0, 299) == 0);
      end
      lvl = ~lvl;
    end
    rst = 1'b0; retry = 1'b0;
    repeat (5) @(negedge refclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
